// File: rtl/cpu_run_controller.sv
// Run-control sequencer for the single-cycle MIPS core: streams a program into
// instruction memory, then gates the core clock-enable to run, step or halt it.
module cpu_run_controller #(
  parameter int unsigned           PC_WIDTH    = 10,
  parameter int unsigned           INST_WIDTH  = 32,
  parameter int unsigned           CYCLE_WIDTH = 16,
  parameter logic [INST_WIDTH-1:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [INST_WIDTH-1:0]  load_data,
  input  logic                   load_last,
  output logic                   load_ready,
  input  logic                   cmd_run,
  input  logic                   cmd_step,
  input  logic                   cmd_halt,
  input  logic                   bp_enable,
  input  logic [PC_WIDTH-1:0]    bp_addr,
  input  logic [PC_WIDTH-1:0]    cpu_pc,
  input  logic [INST_WIDTH-1:0]  cpu_instruction,
  output logic                   cpu_enable,
  output logic                   cpu_reset,
  output logic                   imem_we,
  output logic [PC_WIDTH-1:0]    imem_addr,
  output logic [INST_WIDTH-1:0]  imem_wdata,
  output logic [2:0]             state,
  output logic                   halted,
  output logic [1:0]             halt_cause,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [PC_WIDTH:0]      load_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_STEP = 3'd3,
    S_HALT = 3'd4
  } state_t;

  localparam logic [PC_WIDTH:0] LOAD_ONE = {{PC_WIDTH{1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic [1:0] cause_d;
  logic       resume_q, resume_d;
  logic       clear_count;
  logic       transfer, last_slot;
  logic       op_hit, bp_hit, limit_hit, run_hit;

  assign state      = state_q;
  assign cpu_reset  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign halted     = (state_q == S_HALT);
  // load_count reaching 2^PC_WIDTH means memory is full until the next reset
  assign load_ready = cpu_reset && !load_count[PC_WIDTH];
  assign transfer   = load_valid && load_ready;
  assign last_slot  = &load_count[PC_WIDTH-1:0];

  assign op_hit    = (cpu_instruction == HALT_WORD);
  // resume_q masks the breakpoint on the first RUN cycle after leaving HALT
  assign bp_hit    = bp_enable && (cpu_pc == bp_addr) && !resume_q;
  assign limit_hit = &cycle_count;
  assign run_hit   = op_hit || bp_hit || cmd_halt || limit_hit;

  assign cpu_enable = ((state_q == S_RUN) && !run_hit) || (state_q == S_STEP);

  always_comb begin
    state_d     = state_q;
    cause_d     = halt_cause;
    resume_d    = resume_q;
    clear_count = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          if (!load_last) state_d = S_LOAD;
        end else if (!cmd_halt && (cmd_step || cmd_run)) begin
          state_d     = cmd_step ? S_STEP : S_RUN;
          cause_d     = 2'd0;
          resume_d    = 1'b0;
          clear_count = 1'b1;
        end
      end
      S_LOAD: begin
        if (transfer && (load_last || last_slot)) state_d = S_IDLE;
      end
      S_RUN: begin
        resume_d = 1'b0;
        if (run_hit) begin
          state_d = S_HALT;
          cause_d = op_hit ? 2'd1 : (bp_hit ? 2'd2 : 2'd3);
        end
      end
      S_STEP: begin
        state_d = S_HALT;
        cause_d = 2'd3;
      end
      S_HALT: begin
        if (cmd_halt) begin
          state_d = S_IDLE;
          cause_d = 2'd0;
        end else if (halt_cause != 2'd1) begin
          if (cmd_step) begin
            state_d = S_STEP;
          end else if (cmd_run) begin
            state_d  = S_RUN;
            resume_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      halt_cause  <= '0;
      resume_q    <= 1'b0;
      cycle_count <= '0;
      load_count  <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
    end else begin
      state_q    <= state_d;
      halt_cause <= cause_d;
      resume_q   <= resume_d;
      if (clear_count) begin
        cycle_count <= '0;
      end else if (cpu_enable && !limit_hit) begin
        cycle_count <= cycle_count + 1'b1;
      end
      imem_we <= transfer;
      if (transfer) begin
        imem_addr  <= (state_q == S_IDLE) ? '0 : load_count[PC_WIDTH-1:0];
        imem_wdata <= load_data;
        load_count <= (state_q == S_IDLE) ? LOAD_ONE : load_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller with a small core/instruction-memory plant and an
// instruction-level reference model of where a run stops and why.
module tb_cpu_run_controller;

  localparam int PW    = 6;
  localparam int IW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 64;
  localparam int CMAX  = 255;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0, load_last = 1'b0, load_ready;
  logic [IW-1:0] load_data = '0;
  logic          cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0;
  logic          bp_enable = 1'b0;
  logic [PW-1:0] bp_addr = '0;
  logic [PW-1:0] cpu_pc;
  logic [IW-1:0] cpu_instruction;
  logic          cpu_enable, cpu_reset, imem_we, halted;
  logic [PW-1:0] imem_addr;
  logic [IW-1:0] imem_wdata;
  logic [2:0]    state;
  logic [1:0]    halt_cause;
  logic [CW-1:0] cycle_count;
  logic [PW:0]   load_count;

  int checks = 0;
  int errors = 0;

  logic [31:0]   prog    [DEPTH];
  logic [31:0]   ref_mem [DEPTH];
  logic [31:0]   mem     [DEPTH];
  logic [PW-1:0] core_pc;

  cpu_run_controller #(
    .PC_WIDTH(PW), .INST_WIDTH(IW), .CYCLE_WIDTH(CW), .HALT_WORD(HALT)
  ) dut (
    .clock(clock), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt),
    .bp_enable(bp_enable), .bp_addr(bp_addr),
    .cpu_pc(cpu_pc), .cpu_instruction(cpu_instruction),
    .cpu_enable(cpu_enable), .cpu_reset(cpu_reset),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .state(state), .halted(halted), .halt_cause(halt_cause),
    .cycle_count(cycle_count), .load_count(load_count)
  );

  always #5 clock = ~clock;

  // Core plant: PC advances when enabled, held at 0 in reset; memory written by the controller
  assign cpu_pc          = core_pc;
  assign cpu_instruction = mem[core_pc];
  always @(posedge clock) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
    if (cpu_reset) core_pc <= '0;
    else if (cpu_enable) core_pc <= core_pc + 1'b1;
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    do w = $urandom; while (w == HALT);
    return w;
  endfunction

  task automatic fill_prog(input int n, input int halt_at);
    for (int i = 0; i < n; i++) prog[i] = (i == halt_at) ? HALT : rand_word();
  endtask

  // Instruction-level model: walk the program until a halt condition applies
  function automatic void run_model(input int start_pc, input int start_cnt, input logic resume,
                                    input logic bpe, input int bpa,
                                    output int spc, output int scnt, output int scause);
    int pc = start_pc;
    int cnt = start_cnt;
    logic first = resume;
    scause = 0;
    while (scause == 0) begin
      if (ref_mem[pc] == HALT) scause = 1;
      else if (bpe && pc == bpa && !first) scause = 2;
      else if (cnt == CMAX) scause = 3;
      else begin
        pc = (pc + 1) % DEPTH;
        cnt++;
        first = 1'b0;
      end
    end
    spc  = pc;
    scnt = cnt;
  endfunction

  task automatic load_prog(input int n, input logic use_last);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = use_last && (i == n - 1);
      @(negedge clock);
      ref_mem[i] = prog[i];
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    @(negedge clock);
  endtask

  task automatic pulse_cmd(input logic r, input logic s, input logic h);
    cmd_run = r; cmd_step = s; cmd_halt = h;
    @(negedge clock);
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0;
  endtask

  task automatic wait_halt(output int en);
    int cyc = 0;
    en = 0;
    while (state !== 3'd4 && cyc < 600) begin
      if (cpu_enable === 1'b1) en++;
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset(input logic mid);
    if (mid) begin
      fill_prog(3, -1);
      for (int i = 0; i < 2; i++) begin
        load_valid = 1'b1; load_data = prog[i]; load_last = 1'b0;
        @(negedge clock);
        ref_mem[i] = prog[i];
      end
      load_data = prog[2];
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL midload_state: got %0d expected 1", state); end
    end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state); end
    checks++; if (cpu_reset !== 1'b1 || cpu_enable !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL rst_ctrl: got reset=%b en=%b halted=%b expected 1 0 0", cpu_reset, cpu_enable, halted); end
    checks++; if (imem_we !== 1'b0 || imem_addr !== '0 || imem_wdata !== '0) begin
      errors++; $display("FAIL rst_imem: got we=%b addr=%0d data=%h expected 0 0 0", imem_we, imem_addr, imem_wdata); end
    checks++; if (halt_cause !== 2'd0 || cycle_count !== '0 || load_count !== '0) begin
      errors++; $display("FAIL rst_counts: got cause=%0d cyc=%0d load=%0d expected 0 0 0", halt_cause, cycle_count, load_count); end
    checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", load_ready); end
    load_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_load(input int n);
    int gap;
    fill_prog(n, -1);
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        load_valid = 1'b0;
        @(negedge clock);
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL load_gap_we: got %b expected 0", imem_we); end
      end
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == n - 1);
      @(negedge clock);
      ref_mem[i] = prog[i];
      checks++; if (imem_we !== 1'b1 || imem_addr !== PW'(i) || imem_wdata !== prog[i]) begin
        errors++; $display("FAIL load_write[%0d]: got we=%b addr=%0d data=%h expected 1 %0d %h", i, imem_we, imem_addr, imem_wdata, i, prog[i]); end
      checks++; if (load_count !== (PW+1)'(i + 1)) begin
        errors++; $display("FAIL load_count[%0d]: got %0d expected %0d", i, load_count, i + 1); end
      checks++; if (state !== ((i == n - 1) ? 3'd0 : 3'd1) || load_ready !== 1'b1) begin
        errors++; $display("FAIL load_state[%0d]: got state=%0d ready=%b expected %0d 1", i, state, load_ready, (i == n - 1) ? 0 : 1); end
    end
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clock);
    checks++; if (state !== 3'd0 || load_ready !== 1'b1 || cpu_reset !== 1'b1 || load_count !== (PW+1)'(n)) begin
      errors++; $display("FAIL load_done: got state=%0d ready=%b rst=%b count=%0d expected 0 1 1 %0d", state, load_ready, cpu_reset, load_count, n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (mem[i] !== prog[i]) begin errors++; $display("FAIL load_mem[%0d]: got %h expected %h", i, mem[i], prog[i]); end
    end
  endtask

  task automatic test_full_load_limit();
    int en, spc, scnt, scause;
    fill_prog(DEPTH, -1);
    load_prog(DEPTH, 1'b0);
    checks++; if (state !== 3'd0 || load_count !== (PW+1)'(DEPTH) || load_ready !== 1'b0) begin
      errors++; $display("FAIL full_load: got state=%0d count=%0d ready=%b expected 0 %0d 0", state, load_count, load_ready, DEPTH); end
    load_valid = 1'b1; load_data = rand_word();
    @(negedge clock);
    load_valid = 1'b0;
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL full_refuse: got we=%b expected 0", imem_we); end
    @(negedge clock);
    checks++; if (mem[0] !== prog[0] || mem[DEPTH-1] !== prog[DEPTH-1]) begin
      errors++; $display("FAIL full_mem: got %h %h expected %h %h", mem[0], mem[DEPTH-1], prog[0], prog[DEPTH-1]); end
    run_model(0, 0, 1'b0, 1'b0, 0, spc, scnt, scause);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (state !== 3'd4 || halt_cause !== 2'(scause) || cycle_count !== CW'(scnt) || cpu_pc !== PW'(spc) || en != scnt) begin
      errors++; $display("FAIL limit_run: got state=%0d cause=%0d cyc=%0d pc=%0d en=%0d expected 4 %0d %0d %0d %0d", state, halt_cause, cycle_count, cpu_pc, en, scause, scnt, spc, scnt); end
    pulse_cmd(1'b0, 1'b1, 1'b0);
    wait_halt(en);
    checks++; if (en != 1 || cycle_count !== CW'(CMAX) || cpu_pc !== PW'((spc + 1) % DEPTH) || halt_cause !== 2'd3) begin
      errors++; $display("FAIL limit_step: got en=%0d cyc=%0d pc=%0d cause=%0d expected 1 %0d %0d 3", en, cycle_count, cpu_pc, halt_cause, CMAX, (spc + 1) % DEPTH); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (en != 0 || state !== 3'd4 || halt_cause !== 2'd3) begin
      errors++; $display("FAIL limit_rerun: got en=%0d state=%0d cause=%0d expected 0 4 3", en, state, halt_cause); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++; if (state !== 3'd0 || halt_cause !== 2'd0 || cpu_reset !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("FAIL limit_to_idle: got state=%0d cause=%0d rst=%b halted=%b expected 0 0 1 0", state, halt_cause, cpu_reset, halted); end
    test_reset(1'b0);
  endtask

  task automatic test_halt_opcode(input int h);
    int en, spc, scnt, scause;
    fill_prog(h + 1, h);
    load_prog(h + 1, 1'b1);
    run_model(0, 0, 1'b0, 1'b0, 0, spc, scnt, scause);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (state !== 3'd4 || halted !== 1'b1 || cpu_reset !== 1'b0 || cpu_enable !== 1'b0) begin
      errors++; $display("FAIL op_halt_state: got state=%0d halted=%b rst=%b en=%b expected 4 1 0 0", state, halted, cpu_reset, cpu_enable); end
    checks++; if (halt_cause !== 2'(scause) || cycle_count !== CW'(scnt) || cpu_pc !== PW'(spc) || en != scnt) begin
      errors++; $display("FAIL op_halt_result: got cause=%0d cyc=%0d pc=%0d en=%0d expected %0d %0d %0d %0d", halt_cause, cycle_count, cpu_pc, en, scause, scnt, spc, scnt); end
    pulse_cmd(1'b1, 1'b0, 1'b0);
    @(negedge clock);
    checks++; if (state !== 3'd4 || cpu_pc !== PW'(spc)) begin
      errors++; $display("FAIL op_run_ignored: got state=%0d pc=%0d expected 4 %0d", state, cpu_pc, spc); end
    pulse_cmd(1'b0, 1'b1, 1'b0);
    @(negedge clock);
    checks++; if (state !== 3'd4 || cycle_count !== CW'(scnt)) begin
      errors++; $display("FAIL op_step_ignored: got state=%0d cyc=%0d expected 4 %0d", state, cycle_count, scnt); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++; if (state !== 3'd0 || halt_cause !== 2'd0 || cpu_reset !== 1'b1) begin
      errors++; $display("FAIL op_to_idle: got state=%0d cause=%0d rst=%b expected 0 0 1", state, halt_cause, cpu_reset); end
  endtask

  task automatic test_breakpoint(input int b);
    int en, spc, scnt, scause, rpc, rcnt, rcause;
    fill_prog(16, b + 4);
    load_prog(16, 1'b1);
    bp_enable = 1'b1; bp_addr = PW'(b);
    run_model(0, 0, 1'b0, 1'b1, b, spc, scnt, scause);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (state !== 3'd4 || halt_cause !== 2'(scause) || cpu_pc !== PW'(spc) || cycle_count !== CW'(scnt) || en != scnt) begin
      errors++; $display("FAIL bp_halt: got state=%0d cause=%0d pc=%0d cyc=%0d en=%0d expected 4 %0d %0d %0d %0d", state, halt_cause, cpu_pc, cycle_count, en, scause, spc, scnt, scnt); end
    run_model(spc, scnt, 1'b1, 1'b1, b, rpc, rcnt, rcause);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (state !== 3'd4 || halt_cause !== 2'(rcause) || cpu_pc !== PW'(rpc) || cycle_count !== CW'(rcnt) || en != rcnt - scnt) begin
      errors++; $display("FAIL bp_resume: got state=%0d cause=%0d pc=%0d cyc=%0d en=%0d expected 4 %0d %0d %0d %0d", state, halt_cause, cpu_pc, cycle_count, en, rcause, rpc, rcnt, rcnt - scnt); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    bp_enable = 1'b0;
  endtask

  task automatic test_step();
    int en, spc, scnt, scause;
    int b = $urandom_range(1, 8);
    fill_prog(16, b + 1);
    load_prog(16, 1'b1);
    bp_enable = 1'b1; bp_addr = PW'(b);
    run_model(0, 0, 1'b0, 1'b1, b, spc, scnt, scause);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    wait_halt(en);
    checks++; if (halt_cause !== 2'(scause) || cpu_pc !== PW'(spc)) begin
      errors++; $display("FAIL step_setup: got cause=%0d pc=%0d expected %0d %0d", halt_cause, cpu_pc, scause, spc); end
    for (int i = 1; i <= 3; i++) begin
      pulse_cmd(1'b0, 1'b1, 1'b0);
      wait_halt(en);
      checks++; if (en != 1 || state !== 3'd4 || halt_cause !== 2'd3 || cpu_pc !== PW'(spc + i) || cycle_count !== CW'(scnt + i)) begin
        errors++; $display("FAIL step[%0d]: got en=%0d state=%0d cause=%0d pc=%0d cyc=%0d expected 1 4 3 %0d %0d", i, en, state, halt_cause, cpu_pc, cycle_count, spc + i, scnt + i); end
    end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    bp_enable = 1'b0;
  endtask

  task automatic test_cmd_priority();
    int en;
    pulse_cmd(1'b1, 1'b0, 1'b1);
    @(negedge clock);
    checks++; if (state !== 3'd0 || cpu_reset !== 1'b1 || cpu_enable !== 1'b0) begin
      errors++; $display("FAIL prio_run_halt: got state=%0d rst=%b en=%b expected 0 1 0", state, cpu_reset, cpu_enable); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL prio_idle_halt: got %0d expected 0", state); end
    fill_prog(3, -1);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2); cmd_run = (i == 1);
      @(negedge clock);
      ref_mem[i] = prog[i];
      cmd_run = 1'b0;
      if (i == 1) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL prio_load_ignore: got %0d expected 1", state); end
      end
    end
    load_valid = 1'b0; load_last = 1'b0;
    @(negedge clock);
    pulse_cmd(1'b1, 1'b1, 1'b0);
    checks++; if (state !== 3'd3 || cpu_reset !== 1'b0) begin
      errors++; $display("FAIL prio_run_step: got state=%0d rst=%b expected 3 0", state, cpu_reset); end
    wait_halt(en);
    checks++; if (en != 1 || cycle_count !== CW'(1) || cpu_pc !== PW'(1) || halt_cause !== 2'd3) begin
      errors++; $display("FAIL prio_step_result: got en=%0d cyc=%0d pc=%0d cause=%0d expected 1 1 1 3", en, cycle_count, cpu_pc, halt_cause); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_host_halt();
    int k = $urandom_range(3, 30);
    fill_prog(40, -1);
    load_prog(40, 1'b1);
    pulse_cmd(1'b1, 1'b0, 1'b0);
    repeat (k) @(negedge clock);
    cmd_halt = 1'b1;
    #1;
    checks++; if (cpu_enable !== 1'b0 || state !== 3'd2) begin
      errors++; $display("FAIL host_halt_comb: got en=%b state=%0d expected 0 2", cpu_enable, state); end
    @(negedge clock);
    cmd_halt = 1'b0;
    checks++; if (state !== 3'd4 || halt_cause !== 2'd3 || cycle_count !== CW'(k) || cpu_pc !== PW'(k)) begin
      errors++; $display("FAIL host_halt: got state=%0d cause=%0d cyc=%0d pc=%0d expected 4 3 %0d %0d", state, halt_cause, cycle_count, cpu_pc, k, k); end
    pulse_cmd(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset(1'b0);
    test_full_load_limit();
    test_load(4);
    test_load($urandom_range(5, 20));
    test_halt_opcode(3);
    test_halt_opcode($urandom_range(1, 12));
    test_breakpoint(2);
    test_breakpoint($urandom_range(1, 9));
    test_step();
    test_cmd_priority();
    test_host_halt();
    test_reset(1'b1);
    test_load(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
